dm_responder: RTL and testbench

- Multi-cycle data-memory responder on the far side of the pipeline MEM-stage port (MemAddr, MemWriteData, MemRead, MemWrite, MemReadData).
- Answers each CPU load/store after a fixed, parameterised latency.
- Holds MemBusy high so the pipeline freezes until the access completes.
- Replaces the single-cycle data memory when slow-memory behaviour and pipeline stalls must be modelled.

---
 rtl/dm_pkg.sv | 15 +
 rtl/dm_word_array.sv | 39 +++
 rtl/dm_responder.sv | 163 ++++++++++++++++
 tb/tb_dm_responder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// Optional feature macro used by this design: DM_MISALIGN_CHECK_EN.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dm_state_t;

  localparam int CNT_W = 4;

  localparam logic [31:0] MISALIGN_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/dm_word_array.sv
// DEPTH_WORDS x 32 storage with one synchronous write port and one
// synchronous read port. Contents are never cleared; only the read
// register has a reset value.
module dm_word_array #(
  parameter int DEPTH_WORDS = 32,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [31:0]      i_wdata,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Write port: commit a word when enabled.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: capture a word when enabled, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder for the pipeline MEM-stage port.
// Each load/store is accepted in IDLE, completes LATENCY cycles later and
// MemBusy stalls the pipeline meanwhile.
// Optional feature macro: DM_MISALIGN_CHECK_EN (adds MemErr, suppresses
// misaligned stores and returns MISALIGN_DATA for misaligned loads).
//
// state | meaning
// IDLE  | waiting for MemRead/MemWrite; accepts and latches the request
// BUSY  | access in flight, counter runs down to zero
// DONE  | completion cycle: MemReady pulses, MemBusy low, back to IDLE
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] MemAddr,
  input  logic [31:0] MemWriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] MemReadData,
  output logic        MemBusy,
  output logic        MemReady
`ifdef DM_MISALIGN_CHECK_EN
  ,
  output logic        MemErr
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam bit SINGLE = (LATENCY == 1);
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  dm_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  logic             r_is_wr;
  logic             r_ready;

  logic             w_req;
  logic             w_idle;
  logic             w_fin;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_wdata;
  logic             w_is_wr;
  logic             w_misal;
  logic             w_we;
  logic             w_re;
  logic [31:0]      w_rdata;
  logic             w_unused;

`ifdef DM_MISALIGN_CHECK_EN
  logic [1:0] r_lo;
  logic       r_err;
  logic       r_rd_bad;
`endif

  assign w_req  = MemRead | MemWrite;
  assign w_idle = (r_state == IDLE);

  // With LATENCY==1 the completing edge is the accepting edge, so the live
  // inputs are used there; otherwise the latched copy is used.
  assign w_fin   = (w_idle & w_req & SINGLE) | ((r_state == BUSY) & (r_cnt == '0));
  assign w_idx   = w_idle ? MemAddr[IDX_W+1:2] : r_idx;
  assign w_wdata = w_idle ? MemWriteData : r_wdata;
  assign w_is_wr = w_idle ? MemWrite : r_is_wr;

`ifdef DM_MISALIGN_CHECK_EN
  assign w_misal = w_idle ? (MemAddr[1:0] != 2'b00) : (r_lo != 2'b00);
`else
  assign w_misal = 1'b0;
`endif

  assign w_we = rst_n & w_fin & w_is_wr & ~w_misal;
  assign w_re = rst_n & w_fin & ~w_is_wr;

  assign w_unused = &{1'b0, MemAddr[31:IDX_W+2], MemAddr[1:0]};

  dm_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_arr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (w_idx),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  // Sequencing FSM: accept, count down, complete; outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_is_wr  <= 1'b0;
      r_ready  <= 1'b0;
`ifdef DM_MISALIGN_CHECK_EN
      r_lo     <= 2'b00;
      r_err    <= 1'b0;
      r_rd_bad <= 1'b0;
`endif
    end else begin
      r_ready <= w_fin;
`ifdef DM_MISALIGN_CHECK_EN
      r_err <= w_fin & w_misal;
      if (w_fin & ~w_is_wr) begin
        r_rd_bad <= w_misal;
      end
`endif
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_idx   <= MemAddr[IDX_W+1:2];
            r_wdata <= MemWriteData;
            r_is_wr <= MemWrite;
`ifdef DM_MISALIGN_CHECK_EN
            r_lo    <= MemAddr[1:0];
`endif
            if (SINGLE) begin
              r_state <= DONE;
            end else begin
              r_state <= BUSY;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Stall is low in DONE so the pipeline advances on that edge.
  assign MemBusy  = rst_n & ((w_idle & w_req) | (r_state == BUSY));
  assign MemReady = r_ready;

`ifdef DM_MISALIGN_CHECK_EN
  assign MemErr      = r_err;
  assign MemReadData = r_rd_bad ? MISALIGN_DATA : w_rdata;
`else
  assign MemReadData = w_rdata;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: a LATENCY=2 instance and a LATENCY=1
// instance share the stimulus bus; requests go only to the selected one.
// Covers DM_MISALIGN_CHECK_EN when that macro is defined.
module tb_dm_responder;

  localparam int DEPTH = 32;
  localparam int LAT0  = 2;
  localparam int LAT1  = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic        t_rd;
  logic        t_wr;
  int          t_sel;

  logic        rd0, wr0, rd1, wr1;
  logic [31:0] rdata0, rdata1;
  logic        busy0, busy1, ready0, ready1;
  logic        err0, err1;

  logic [31:0] s_rdata;
  logic        s_busy, s_ready, s_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model [2][DEPTH];
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  assign rd0 = t_rd & (t_sel == 0);
  assign wr0 = t_wr & (t_sel == 0);
  assign rd1 = t_rd & (t_sel == 1);
  assign wr1 = t_wr & (t_sel == 1);

  dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u_dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .MemAddr      (t_addr),
    .MemWriteData (t_wdata),
    .MemRead      (rd0),
    .MemWrite     (wr0),
    .MemReadData  (rdata0),
    .MemBusy      (busy0),
    .MemReady     (ready0)
`ifdef DM_MISALIGN_CHECK_EN
    ,
    .MemErr       (err0)
`endif
  );

  dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .MemAddr      (t_addr),
    .MemWriteData (t_wdata),
    .MemRead      (rd1),
    .MemWrite     (wr1),
    .MemReadData  (rdata1),
    .MemBusy      (busy1),
    .MemReady     (ready1)
`ifdef DM_MISALIGN_CHECK_EN
    ,
    .MemErr       (err1)
`endif
  );

`ifndef DM_MISALIGN_CHECK_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  assign s_rdata = (t_sel == 0) ? rdata0 : rdata1;
  assign s_busy  = (t_sel == 0) ? busy0  : busy1;
  assign s_ready = (t_sel == 0) ? ready0 : ready1;
  assign s_err   = (t_sel == 0) ? err0   : err1;

  // One load/store on the selected instance, driven away from the rising edge.
  // The request is held through the DONE cycle, as a stalled pipeline would.
  task automatic access(input int sel, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit corrupt);
    int lat;
    int idx;
    bit misal;
    bit done;
    logic [31:0] exp;
    lat = (sel == 0) ? LAT0 : LAT1;
    idx = int'((addr >> 2) % DEPTH);
`ifdef DM_MISALIGN_CHECK_EN
    misal = ((addr % 4) != 0);
`else
    misal = 1'b0;
`endif
    if (wr) begin
      if (!misal) model[sel][idx] = wdata;
    end else begin
      sb.push_back(misal ? 32'hDEADBEEF : model[sel][idx]);
    end
    t_sel = sel; t_addr = addr; t_wdata = wdata; t_rd = !wr; t_wr = wr;
    done = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 0) #1; else @(negedge clk);
      if (s_ready === 1'b1) begin
        n_checks++;
        if (cyc != lat) begin
          n_errors++;
          $display("FAIL latency addr=%h: ready in cycle %0d, required %0d", addr, cyc, lat);
        end
        n_checks++;
        if (s_busy !== 1'b0) begin
          n_errors++;
          $display("FAIL busy_in_done addr=%h: got %b, required 0", addr, s_busy);
        end
        n_checks++;
        if (s_err !== misal) begin
          n_errors++;
          $display("FAIL err addr=%h: got %b, required %b", addr, s_err, misal);
        end
        if (!wr) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty addr=%h: got data %h, nothing required", addr, s_rdata);
          end else begin
            exp = sb.pop_front();
            if (s_rdata !== exp) begin
              n_errors++;
              $display("FAIL rdata addr=%h: got %h, required %h", addr, s_rdata, exp);
            end
          end
        end
        done = 1'b1;
        break;
      end else begin
        n_checks++;
        if (s_busy !== 1'b1) begin
          n_errors++;
          $display("FAIL busy addr=%h cycle %0d: got %b, required 1", addr, cyc, s_busy);
        end
      end
      if (corrupt && cyc == 1) begin
        t_addr = 32'h14; t_wdata = 32'hBAD0BAD0;
      end
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL timeout addr=%h: no MemReady within 40 cycles, required cycle %0d", addr, lat);
    end
    @(posedge clk); #1;
    t_rd = 1'b0; t_wr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b0 || s_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL after_done addr=%h: ready=%b busy=%b, required 0 0", addr, s_ready, s_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; t_addr = '0; t_wdata = '0; t_rd = 1'b0; t_wr = 1'b0; t_sel = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy0, ready0, err0, busy1, ready1, err1} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b, required 000000", {busy0, ready0, err0, busy1, ready1, err1});
    end
    n_checks++;
    if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_rdata: got %h %h, required 0 0", rdata0, rdata1);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    access(0, 1'b1, 32'h14, 32'h0000_0777, 1'b0);
    access(0, 1'b1, 32'h10, 32'h1234_5678, 1'b1);
    access(0, 1'b0, 32'h10, 32'h0, 1'b0);
    access(0, 1'b0, 32'h14, 32'h0, 1'b0);
    access(0, 1'b1, 32'h18, 32'h0000_0099, 1'b0);
    n_checks++;
    if (rdata0 !== 32'h0000_0777) begin
      n_errors++;
      $display("FAIL rdata_hold_after_store: got %h, required 00000777", rdata0);
    end
  endtask

  task automatic test_latency1();
    access(1, 1'b1, 32'h04, 32'hA5A5_A5A5, 1'b0);
    access(1, 1'b0, 32'h04, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] busy_v;
    logic [5:0] ready_v;
    access(0, 1'b1, 32'h40, 32'hCAFE_F00D, 1'b0);
    sb.push_back(model[0][16]);
    sb.push_back(model[0][16]);
    t_sel = 0; t_addr = 32'h40; t_rd = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc == 0) #1; else @(negedge clk);
      busy_v[cyc]  = s_busy;
      ready_v[cyc] = s_ready;
      if (s_ready === 1'b1 && sb.size() > 0) begin
        n_checks++;
        if (s_rdata !== sb[0]) begin
          n_errors++;
          $display("FAIL b2b_rdata cycle %0d: got %h, required %h", cyc, s_rdata, sb[0]);
        end
        void'(sb.pop_front());
      end
    end
    @(posedge clk); #1;
    t_rd = 1'b0;
    n_checks++;
    if (busy_v !== 6'b011011) begin
      n_errors++;
      $display("FAIL b2b_busy: got %b, required 011011", busy_v);
    end
    n_checks++;
    if (ready_v !== 6'b100100) begin
      n_errors++;
      $display("FAIL b2b_ready: got %b, required 100100", ready_v);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (s_ready !== 1'b0 || s_busy !== 1'b0) begin
        n_errors++;
        $display("FAIL b2b_idle cycle %0d: ready=%b busy=%b, required 0 0", i, s_ready, s_busy);
      end
    end
    sb.delete();
  endtask

  task automatic test_wrap();
    access(0, 1'b1, 32'h80, 32'h0000_0001, 1'b0);
    access(0, 1'b0, 32'h00, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid_busy();
    access(0, 1'b1, 32'h20, 32'h1111_2222, 1'b0);
    t_sel = 0; t_addr = 32'h20; t_wdata = 32'hFFFF_0000; t_wr = 1'b1;
    #1;
    n_checks++;
    if (busy0 !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_busy_pre: got %b, required 1", busy0);
    end
    @(posedge clk); #1;
    rst_n = 1'b0; t_wr = 1'b0;
    #1;
    n_checks++;
    if (busy0 !== 1'b0 || ready0 !== 1'b0 || rdata0 !== 32'h0) begin
      n_errors++;
      $display("FAIL rst_immediate: busy=%b ready=%b rdata=%h, required 0 0 0", busy0, ready0, rdata0);
    end
    @(negedge clk);
    @(posedge clk); #1;
    n_checks++;
    if (busy0 !== 1'b0 || ready0 !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_held: busy=%b ready=%b, required 0 0", busy0, ready0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    access(0, 1'b0, 32'h20, 32'h0, 1'b0);
  endtask

  task automatic test_misalign();
    access(0, 1'b1, 32'h10, 32'hCAFE_0000, 1'b0);
    access(0, 1'b0, 32'h13, 32'h0, 1'b0);
    access(0, 1'b1, 32'h11, 32'h0000_5555, 1'b0);
    access(0, 1'b0, 32'h10, 32'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_latency1();
    test_back_to_back();
    test_wrap();
    test_reset_mid_busy();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
